// File: rtl/example_serdes_pkg.sv
// Shared types and helpers for the example SerDes lane: aligner states,
// the default K28.5 comma and the comma matcher.
package example_serdes_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    localparam logic [9:0] K28_5 = 10'b0011111010;

    // Words are passed zero-extended to 32 bits; width selects the live bits,
    // so a match against either running-disparity form of the comma is exact.
    function automatic logic is_comma(input logic [31:0] word,
                                      input logic [31:0] comma,
                                      input int          width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (word == (comma & mask)) || (word == (~comma & mask));
    endfunction

endpackage

// File: rtl/example_word_aligner.sv
// Comma-based RX word aligner: HUNT/VERIFY/LOCKED tracking of the comma phase
// against the free-running bit counter, plus the registered RX word outputs.
module example_word_aligner
    import example_serdes_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 10,
    parameter logic [DATA_WIDTH-1:0] COMMA        = DATA_WIDTH'(K28_5),
    parameter int                    LOCK_COUNT   = 4,
    parameter int                    UNLOCK_COUNT = 8,
    localparam int                   CW           = $clog2(DATA_WIDTH)
) (
    input  logic                  fastClk,
    input  logic                  resetIn_n,
    input  logic [CW-1:0]         bit_cnt,
    input  logic [DATA_WIDTH-1:0] window,
    output logic [DATA_WIDTH-1:0] data_rx,
    output logic                  data_rx_valid,
    output logic                  data_rx_comma,
    output logic                  rx_locked
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);

    align_state_t  state, state_nxt;
    logic [CW-1:0] phase;
    logic [GW-1:0] good;
    logic [BW-1:0] bad;
    logic          comma_hit, in_phase, emit;

    assign comma_hit = is_comma(32'(window), 32'(COMMA), DATA_WIDTH);
    assign in_phase  = (bit_cnt == phase);

    always_ff @(posedge fastClk or negedge resetIn_n) begin
        if (!resetIn_n) state <= HUNT;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:
                if (comma_hit) state_nxt = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
            VERIFY:
                if (comma_hit) begin
                    if (!in_phase)                         state_nxt = HUNT;
                    else if (good == GW'(LOCK_COUNT - 1))  state_nxt = LOCKED;
                end
            LOCKED:
                if (comma_hit && !in_phase && bad == BW'(UNLOCK_COUNT - 1))
                    state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    // The word completing a lock is emitted along with every in-phase word.
    always_comb begin
        rx_locked = (state == LOCKED);
        emit      = (state == LOCKED) ? in_phase : (state_nxt == LOCKED);
    end

    always_ff @(posedge fastClk or negedge resetIn_n) begin
        if (!resetIn_n) begin
            phase         <= '0;
            good          <= '0;
            bad           <= '0;
            data_rx       <= '0;
            data_rx_valid <= 1'b0;
            data_rx_comma <= 1'b0;
        end else begin
            if (comma_hit) begin
                case (state)
                    HUNT: begin
                        phase <= bit_cnt;
                        good  <= GW'(1);
                        bad   <= '0;
                    end
                    VERIFY: begin
                        if (in_phase) good <= good + GW'(1);
                        bad <= '0;
                    end
                    LOCKED: begin
                        if (in_phase) bad <= '0;
                        else          bad <= bad + BW'(1);
                    end
                    default: ;
                endcase
            end
            data_rx_valid <= emit;
            if (emit) begin
                data_rx       <= window;
                data_rx_comma <= comma_hit;
            end
        end
    end

endmodule

// File: rtl/example_serdes_lane.sv
// Bit-rate SerDes lane: free-running bit counter, TX shifter, RX sampler and
// word aligner. Define EXAMPLE_SERDES_LOOPBACK_EN to add the internal loopback port.
module example_serdes_lane
    import example_serdes_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 10,
    parameter logic [DATA_WIDTH-1:0] COMMA        = DATA_WIDTH'(K28_5),
    parameter logic [DATA_WIDTH-1:0] TX_IDLE      = COMMA,
    parameter int                    LOCK_COUNT   = 4,
    parameter int                    UNLOCK_COUNT = 8
) (
    input  logic                  fastClk,
    input  logic                  resetIn_n,
    input  logic                  rx_p,
    input  logic                  rx_n,
    output logic                  tx_p,
    output logic                  tx_n,
    input  logic [DATA_WIDTH-1:0] data_tx,
    input  logic                  data_tx_valid,
    output logic                  data_tx_ready,
    output logic [DATA_WIDTH-1:0] data_rx,
    output logic                  data_rx_valid,
    output logic                  data_rx_comma,
    output logic                  rx_locked,
    output logic                  rx_diff_err
`ifdef EXAMPLE_SERDES_LOOPBACK_EN
    ,
    input  logic                  loopback
`endif
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] window;
    logic                  rx_bit, rx_bad;

    assign data_tx_ready = (bit_cnt == CW'(DATA_WIDTH - 1));
    assign tx_p          = tx_shift[DATA_WIDTH-1];
    assign tx_n          = ~tx_p;

    always_ff @(posedge fastClk or negedge resetIn_n) begin
        if (!resetIn_n) begin
            bit_cnt  <= '0;
            tx_shift <= '0;
        end else begin
            bit_cnt <= data_tx_ready ? '0 : bit_cnt + CW'(1);
            if (data_tx_ready) tx_shift <= data_tx_valid ? data_tx : TX_IDLE;
            else               tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // A non-differential sample is untrustworthy, so it enters the window as 0.
    always_comb begin
        rx_bad = (rx_p == rx_n);
        rx_bit = rx_p & ~rx_bad;
`ifdef EXAMPLE_SERDES_LOOPBACK_EN
        if (loopback) begin
            rx_bit = tx_p;
            rx_bad = 1'b0;
        end
`endif
    end

    always_ff @(posedge fastClk or negedge resetIn_n) begin
        if (!resetIn_n) begin
            window      <= '0;
            rx_diff_err <= 1'b0;
        end else begin
            window      <= {window[DATA_WIDTH-2:0], rx_bit};
            rx_diff_err <= rx_diff_err | rx_bad;
        end
    end

    example_word_aligner #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COMMA       (COMMA),
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT)
    ) u_aligner (
        .fastClk      (fastClk),
        .resetIn_n    (resetIn_n),
        .bit_cnt      (bit_cnt),
        .window       (window),
        .data_rx      (data_rx),
        .data_rx_valid(data_rx_valid),
        .data_rx_comma(data_rx_comma),
        .rx_locked    (rx_locked)
    );

endmodule

// File: tb/tb_example_serdes_lane.sv
// Directed bench for example_serdes_lane: idle TX stream, lock over a TX->RX
// loop, phase slip with unlock/relock, diff-error stickiness, mid-word reset.
module tb_example_serdes_lane;

    localparam logic [9:0] K = 10'b0011111010;

    logic       fastClk = 1'b0;
    logic       resetIn_n;
    logic       rx_p, rx_n, tx_p, tx_n;
    logic [9:0] data_tx;
    logic       data_tx_valid, data_tx_ready;
    logic [9:0] data_rx;
    logic       data_rx_valid, data_rx_comma, rx_locked, rx_diff_err;
`ifdef EXAMPLE_SERDES_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    // RX source: direct TX loop, TX delayed 3 bits (slip), or both legs forced high.
    logic       slip = 1'b0, force_eq = 1'b0;
    logic [2:0] hist = '0;
    logic       rx_src;

    int cyc, n_chk, n_fail;

    always #5 fastClk = ~fastClk;
    always @(posedge fastClk) hist <= {hist[1:0], tx_p};

    assign rx_src = slip ? hist[2] : tx_p;
    assign rx_p   = force_eq ? 1'b1 : rx_src;
    assign rx_n   = force_eq ? 1'b1 : ~rx_src;

    example_serdes_lane dut (
        .fastClk      (fastClk),
        .resetIn_n    (resetIn_n),
        .rx_p         (rx_p),
        .rx_n         (rx_n),
        .tx_p         (tx_p),
        .tx_n         (tx_n),
        .data_tx      (data_tx),
        .data_tx_valid(data_tx_valid),
        .data_tx_ready(data_tx_ready),
        .data_rx      (data_rx),
        .data_rx_valid(data_rx_valid),
        .data_rx_comma(data_rx_comma),
        .rx_locked    (rx_locked),
        .rx_diff_err  (rx_diff_err)
`ifdef EXAMPLE_SERDES_LOOPBACK_EN
        ,
        .loopback     (loopback)
`endif
    );

    task automatic step();
        @(posedge fastClk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_p"}, tx_p, 0);
        check({tag, "_tx_n"}, tx_n, 1);
        check({tag, "_ready"}, data_tx_ready, 0);
        check({tag, "_data_rx"}, data_rx, 0);
        check({tag, "_rx_valid"}, data_rx_valid, 0);
        check({tag, "_rx_comma"}, data_rx_comma, 0);
        check({tag, "_locked"}, rx_locked, 0);
        check({tag, "_diff_err"}, rx_diff_err, 0);
    endtask

    initial begin
        logic [29:0] rdy_mask;
        logic [9:0]  w1, w2, w;
        int          txn_bad, vcnt, lcnt;

        n_chk = 0; n_fail = 0; cyc = 0;
        resetIn_n = 1'b1; data_tx = '0; data_tx_valid = 1'b0;
        #1 resetIn_n = 1'b0;
        #3 check_reset_values("reset");
        @(negedge fastClk); @(negedge fastClk);
        resetIn_n = 1'b1;

        // Idle TX stream, ready strobe and differential TX legs
        rdy_mask = '0; w1 = '0; w2 = '0; txn_bad = 0;
        for (int c = 0; c < 30; c++) begin
            rdy_mask[c] = data_tx_ready;
            if (tx_n !== ~tx_p) txn_bad++;
            if (c >= 10 && c < 20) w1 = {w1[8:0], tx_p};
            if (c >= 20)           w2 = {w2[8:0], tx_p};
            if (c == 29) begin data_tx = 10'h0FA; data_tx_valid = 1'b1; end
            step();
        end
        check("ready_strobe", rdy_mask, 30'h2008_0200);
        check("idle_word1", w1, K);
        check("idle_word2", w2, K);
        check("tx_n_inverse", txn_bad, 0);

        // Commas then 0x155 over the loop: lock on the 4th comma
        run_to(49); data_tx = 10'h155;
        step();
        data_tx_valid = 1'b0;
        check("lock_before_4th", rx_locked, 0);
        w = '0; vcnt = 0;
        for (int c = 50; c < 61; c++) begin
            if (c < 60) w = {w[8:0], tx_p};
            if (c == 51) begin
                check("lock_rise", rx_locked, 1);
                check("lock_word_valid", data_rx_valid, 1);
                check("lock_word_data", data_rx, 10'h0FA);
                check("lock_word_comma", data_rx_comma, 1);
            end
            if (c >= 52) vcnt += int'(data_rx_valid);
            step();
        end
        check("tx_word_155", w, 10'h155);
        check("no_valid_midword", vcnt, 0);
        check("rx155_valid", data_rx_valid, 1);
        check("rx155_data", data_rx, 10'h155);
        check("rx155_comma", data_rx_comma, 0);
        step();
        check("rx_valid_pulse_end", data_rx_valid, 0);
        check("rx_data_hold", data_rx, 10'h155);

        // Slip RX by 3 bits: 8 misaligned commas drop lock, 4 in-phase relock
        run_to(70); slip = 1'b1;
        run_to(153);
        check("locked_before_8th_bad", rx_locked, 1);
        step();
        check("unlock_on_8th_bad", rx_locked, 0);
        vcnt = 0; lcnt = 0;
        while (cyc < 194) begin
            vcnt += int'(data_rx_valid);
            lcnt += int'(rx_locked);
            step();
        end
        check("no_valid_unlocked", vcnt, 0);
        check("stay_unlocked", lcnt, 0);
        check("relock", rx_locked, 1);
        check("relock_valid", data_rx_valid, 1);
        check("relock_data", data_rx, 10'h0FA);
        check("relock_comma", data_rx_comma, 1);

        // Non-differential RX sample sets the sticky error
        run_to(200);
        check("diff_err_clear", rx_diff_err, 0);
        force_eq = 1'b1;
        step();
        force_eq = 1'b0;
        check("diff_err_set", rx_diff_err, 1);
        run_to(215);
        check("diff_err_sticky", rx_diff_err, 1);
        check("locked_after_diff", rx_locked, 1);

        // Asynchronous reset mid-word while locked
        run_to(225);
        check("locked_before_reset", rx_locked, 1);
        #2 resetIn_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge fastClk);
        resetIn_n = 1'b1; cyc = 0; slip = 1'b0;
`ifdef EXAMPLE_SERDES_LOOPBACK_EN
        loopback = 1'b1; force_eq = 1'b1;
`endif
        w = '0;
        for (int c = 0; c < 20; c++) begin
            if (c == 9) check("post_reset_ready", data_tx_ready, 1);
            if (c >= 10) w = {w[8:0], tx_p};
            step();
        end
        check("post_reset_idle_word", w, K);
        run_to(50);
        check("post_reset_unlocked", rx_locked, 0);
        step();
        check("post_reset_lock", rx_locked, 1);
        run_to(59); data_tx = 10'h2AA; data_tx_valid = 1'b1;
        step();
        data_tx_valid = 1'b0;
        run_to(71);
        check("return_valid", data_rx_valid, 1);
        check("return_data", data_rx, 10'h2AA);
        check("return_comma", data_rx_comma, 0);
        check("return_no_diff_err", rx_diff_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
